seg_scroller: RTL
=================

SEG_SCROLLER -- requirements
Module: seg_scroller

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, message buffer depth in characters.
REQ-002 SHALL have parameter DWELL, default 4, clk_2 cycles each character is shown (DWELL >= 1).
REQ-003 SHALL have parameter GAP, default 1, blank clk_2 cycles between characters (GAP >= 1).
REQ-004 SHALL have ports: clk_2 input 1 (sole clock); reset input 1 (synchronous, active-high).
REQ-005 SHALL have ports: wr_en input 1 (buffer write strobe); wr_addr input 4 (buffer index); wr_data input 6 (character code).
REQ-006 SHALL have ports: len input 5 (message length, 0..MAX_LEN, sampled at start); loop input 1 (restart after last character).
REQ-007 SHALL have ports: start input 1 (begin playback); stop input 1 (abort); hold input 1 (freeze timing).
REQ-008 SHALL have ports: SEG output 8 (bits 6:0 segments g..a, bit 7 decimal point); busy output 1; done output 1 (one-cycle pulse); char_idx output 4 (current index).

Function
REQ-009 SHALL store wr_data at buffer[wr_addr] on each clk_2 edge with wr_en=1, in any state, including during playback.
REQ-010 SHALL decode character codes: 0-15 hex digits 0-F; 16-41 letters A b C c d E F g H h I i J L n O o P q r S t U u y degree; 42-63 dash 7'b1000000.
REQ-011 SHALL implement FSM states IDLE, SHOW, GAP, DONE; reset state IDLE.
REQ-012 IDLE: SEG=0, busy=0; start=1 with len!=0 -> SHOW, idx=0, cnt=0, len latched; start with len=0 ignored.
REQ-013 SHOW: SEG[6:0]=decode(buffer[idx]); SEG[7]=1 only when idx==latched_len-1; cnt increments each cycle; at cnt==DWELL-1 -> GAP, cnt=0.
REQ-014 GAP: SEG=0; at cnt==GAP-1: if idx<latched_len-1 -> SHOW, idx+1; else if loop=1 -> SHOW, idx=0; else -> DONE.
REQ-015 DONE: SEG=0, done=1 for exactly one cycle, then IDLE.
REQ-016 busy SHALL be 1 in SHOW and GAP, 0 in IDLE and DONE.
REQ-017 hold=1 SHALL freeze cnt, idx and state in SHOW/GAP; SEG keeps its current value.
REQ-018 stop=1 SHALL force IDLE on next edge from any state, with priority over hold, start and counter expiry; done not asserted.
REQ-019 start while busy SHALL be ignored; loop SHALL be sampled live at each wrap decision.
REQ-020 SEG, busy, done, char_idx SHALL be combinational from registered state/idx/buffer: first character visible in the cycle after the edge sampling start.
REQ-021 A buffer write to the index being shown SHALL change SEG in the following cycle.

Reset
REQ-022 reset SHALL, on clk_2 edge, set state IDLE, idx=0, cnt=0, latched_len=0; outputs then SEG=0, busy=0, done=0, char_idx=0.
REQ-023 reset SHALL NOT clear buffer contents; reset mid-playback SHALL take precedence over stop, start and wr_en.

Structure
REQ-024 Package seg_pkg SHALL hold char code typedef (6 bits), FSM state enum, segment constants SEG_BLANK=7'b0000000, SEG_DASH=7'b1000000.
REQ-025 Character decode SHALL be a combinational sub-module seg7_font (6-bit code in, 7-bit pattern out).

Verification
REQ-026 Load 33,16,22 (P,A,F), len=3, loop=0, start -> SEG 8'h73 x4, 0 x1, 8'h77 x4, 0 x1, 8'hF1 x4, 0 x1, done pulse, IDLE.
REQ-027 Same message, loop=1 -> after F and gap, SEG 8'h73 again; stop mid-A -> IDLE next cycle, SEG=0, no done.
REQ-028 hold=1 for 3 cycles during second cycle of P -> P shown 7 cycles total; char_idx unchanged.
REQ-029 len=0, start -> remains IDLE, busy=0; start pulse while busy -> sequence unaffected.
REQ-030 Write code 50 to index 1 while showing index 0 -> index 1 shows 8'h40; write code 9 to index 0 while shown -> SEG 8'h6F next cycle.
REQ-031 reset during GAP of index 1 -> IDLE, SEG=0; restart shows previously loaded buffer intact.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment message scroller.
//   char_t   : 6-bit character code stored in the message buffer
//   state_t  : playback FSM states
//   SEG_*    : segment patterns, bit 0 = a ... bit 6 = g
package seg_pkg;

    localparam int unsigned CODE_W = 6;
    localparam int unsigned SEG_W  = 7;

    typedef logic [CODE_W-1:0] char_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;

endpackage

// File: rtl/seg7_font.sv
// Character code to seven-segment pattern decoder (pure combinational).
//   code    : 6-bit character code (0-15 hex, 16-41 letters, 42-63 dash)
//   pattern : segments g..a in bits 6..0, active high
module seg7_font
    import seg_pkg::*;
(
    input  char_t              code,
    output logic [SEG_W-1:0]   pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (code)
            6'd0:  pattern = 7'h3F;  // 0
            6'd1:  pattern = 7'h06;  // 1
            6'd2:  pattern = 7'h5B;  // 2
            6'd3:  pattern = 7'h4F;  // 3
            6'd4:  pattern = 7'h66;  // 4
            6'd5:  pattern = 7'h6D;  // 5
            6'd6:  pattern = 7'h7D;  // 6
            6'd7:  pattern = 7'h07;  // 7
            6'd8:  pattern = 7'h7F;  // 8
            6'd9:  pattern = 7'h6F;  // 9
            6'd10: pattern = 7'h77;  // A
            6'd11: pattern = 7'h7C;  // b
            6'd12: pattern = 7'h39;  // C
            6'd13: pattern = 7'h5E;  // d
            6'd14: pattern = 7'h79;  // E
            6'd15: pattern = 7'h71;  // F
            6'd16: pattern = 7'h77;  // A
            6'd17: pattern = 7'h7C;  // b
            6'd18: pattern = 7'h39;  // C
            6'd19: pattern = 7'h58;  // c
            6'd20: pattern = 7'h5E;  // d
            6'd21: pattern = 7'h79;  // E
            6'd22: pattern = 7'h71;  // F
            6'd23: pattern = 7'h6F;  // g
            6'd24: pattern = 7'h76;  // H
            6'd25: pattern = 7'h74;  // h
            6'd26: pattern = 7'h30;  // I
            6'd27: pattern = 7'h10;  // i
            6'd28: pattern = 7'h1E;  // J
            6'd29: pattern = 7'h38;  // L
            6'd30: pattern = 7'h54;  // n
            6'd31: pattern = 7'h3F;  // O
            6'd32: pattern = 7'h5C;  // o
            6'd33: pattern = 7'h73;  // P
            6'd34: pattern = 7'h67;  // q
            6'd35: pattern = 7'h50;  // r
            6'd36: pattern = 7'h6D;  // S
            6'd37: pattern = 7'h78;  // t
            6'd38: pattern = 7'h3E;  // U
            6'd39: pattern = 7'h1C;  // u
            6'd40: pattern = 7'h6E;  // y
            6'd41: pattern = 7'h63;  // degree
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scroller.sv
// Plays a stored message one character at a time on a seven-segment digit.
//   clk_2, reset          : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : message buffer write port (usable at any time)
//   len, loop             : message length (latched at start), repeat enable
//   start, stop, hold     : begin playback, abort, freeze timing
//   SEG                   : {dp, g..a}; dp lights on the last character
//   busy, done, char_idx  : playing, one-cycle end pulse, current index
module seg_scroller
    import seg_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned DWELL   = 4,
    parameter int unsigned GAP     = 1
) (
    input  logic        clk_2,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [5:0]  wr_data,
    input  logic [4:0]  len,
    input  logic        loop,
    input  logic        start,
    input  logic        stop,
    input  logic        hold,
    output logic [7:0]  SEG,
    output logic        busy,
    output logic        done,
    output logic [3:0]  char_idx
);

    localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    char_t              buffer [MAX_LEN];
    state_t             state;
    logic [3:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic [4:0]         len_q;
    logic               last;
    logic [SEG_W-1:0]   pattern;

    assign last = ({1'b0, idx} == (len_q - 5'd1));

    // Buffer is deliberately outside reset so a message survives it.
    always_ff @(posedge clk_2) begin
        if (!reset && wr_en && (32'(wr_addr) < MAX_LEN)) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // Playback FSM: stop beats hold/start/expiry; hold freezes SHOW and GAP.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= 4'd0;
            cnt   <= '0;
            len_q <= 5'd0;
        end else if (stop) begin
            state <= ST_IDLE;
            idx   <= 4'd0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (len != 5'd0)) begin
                        state <= ST_SHOW;
                        idx   <= 4'd0;
                        cnt   <= '0;
                        len_q <= len;
                    end
                end
                ST_SHOW: begin
                    if (!hold) begin
                        if (cnt == CNT_W'(DWELL - 1)) begin
                            state <= ST_GAP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!hold) begin
                        if (cnt == CNT_W'(GAP - 1)) begin
                            cnt <= '0;
                            if (!last) begin
                                state <= ST_SHOW;
                                idx   <= idx + 4'd1;
                            end else if (loop) begin
                                state <= ST_SHOW;
                                idx   <= 4'd0;
                            end else begin
                                state <= ST_DONE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= 4'd0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    seg7_font u_font (
        .code    (buffer[idx]),
        .pattern (pattern)
    );

    // Outputs follow registered state directly so buffer writes show next cycle.
    assign SEG      = (state == ST_SHOW) ? {last, pattern} : {1'b0, SEG_BLANK};
    assign busy     = (state == ST_SHOW) || (state == ST_GAP);
    assign done     = (state == ST_DONE);
    assign char_idx = idx;

endmodule
